pulse_pair_transmitter: RTL and testbench

Transmit side of the dual-line pulse-count interface consumed by the divisible-by-six checker. Accepts a parallel count, serialises it as unary pulses on two lines (X, Y) at up to two pulses per clock, and signals completion. It also tracks the mod-6 residue of the emitted pulses, so a bench or a downstream controller can cross-check the receiver's `divisable` flag.

---
 rtl/pulse_if_pkg.sv | 17 +
 rtl/mod6_accum.sv | 23 ++
 rtl/pulse_pair_transmitter.sv | 107 ++++++++++
 tb/tb_pulse_pair_transmitter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_if_pkg.sv
// pulse_if_pkg: shared types and constants for the X/Y pulse-count interface.
package pulse_if_pkg;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam int RES_W = 3;
    localparam logic [RES_W:0] MOD = (RES_W + 1)'(6);

    function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a, input logic [1:0] b);
        logic [RES_W:0] s;
        logic [RES_W:0] d;
        s = {1'b0, a} + (RES_W + 1)'(b);
        d = s - MOD;
        return (s >= MOD) ? d[RES_W-1:0] : s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod6_accum.sv
// mod6_accum: registered modulo-6 accumulator of 0..2 pulses per cycle.
//   clk, reset - clock, asynchronous active-high reset
//   clr        - synchronous clear to 0 (has priority over inc)
//   inc        - pulses to add this cycle (0..2)
//   res        - current residue, 0..5
module mod6_accum
    import pulse_if_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [RES_W-1:0] res
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            res <= '0;
        else
            res <= clr ? '0 : mod_add(res, inc);
    end

endmodule

// File: rtl/pulse_pair_transmitter.sv
// pulse_pair_transmitter: serialises a parallel count as unary pulses on X/Y.
//   clk, reset     - clock, asynchronous active-high reset
//   start          - send request, taken only while idle
//   count, single  - pulse count and one-pulse-per-cycle mode, latched on start
//   X_out, Y_out   - registered pulse lines
//   busy, done     - transfer in progress / one-cycle completion strobe
//   div6           - emitted pulse total is a multiple of 6 (valid in done cycle)
module pulse_pair_transmitter
    import pulse_if_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] count,
    input  logic         single,
    output logic         X_out,
    output logic         Y_out,
    output logic         busy,
    output logic         done,
    output logic         div6
);

    state_t state, state_nx;
    logic [W-1:0] rem, rem_nx;
    logic mode, mode_nx;
    logic alt, alt_nx;
    logic x_nx, y_nx;
    logic accept;
    logic [1:0] p;
    logic [RES_W-1:0] res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            mode  <= 1'b0;
            alt   <= 1'b0;
            X_out <= 1'b0;
            Y_out <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            mode  <= mode_nx;
            alt   <= alt_nx;
            X_out <= x_nx;
            Y_out <= y_nx;
        end
    end

    // Pulses are launched on the edges leaving SEND; the SEND cycle that finds
    // rem already at 0 is the one displaying the final pulse, so DONE (and the
    // done strobe) lands in the cycle right after the last visible pulse.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        mode_nx  = mode;
        alt_nx   = alt;
        x_nx     = 1'b0;
        y_nx     = 1'b0;
        p        = 2'd0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    rem_nx   = count;
                    mode_nx  = single;
                    alt_nx   = 1'b0;
                    state_nx = (count == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (rem == '0) begin
                    state_nx = DONE;
                end else if (mode) begin
                    x_nx   = ~alt;
                    y_nx   = alt;
                    p      = 2'd1;
                    alt_nx = ~alt;
                end else begin
                    x_nx = 1'b1;
                    y_nx = (rem >= W'(2));
                    p    = (rem >= W'(2)) ? 2'd2 : 2'd1;
                end
                rem_nx = rem - W'(p);
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    mod6_accum u_accum (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .inc  (p),
        .res  (res)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    // Residue is only cleared by the next accepted start, so this holds after done.
    assign div6 = (res == '0);

endmodule

// File: tb/tb_pulse_pair_transmitter.sv
module tb_pulse_pair_transmitter;

    typedef struct {
        int n;
        bit s;
    } xfer_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       single = 1'b0;
    logic [7:0] count = 8'd0;
    logic       X_out, Y_out, busy, done, div6;

    int tests = 0;
    int fails = 0;
    int rres = 0;
    bit prev_done = 1'b0;
    logic [1:0] obs[$];
    xfer_t sb[$];

    always #5 clk = ~clk;

    pulse_pair_transmitter #(.W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
        .single(single),
        .X_out (X_out),
        .Y_out (Y_out),
        .busy  (busy),
        .done  (done),
        .div6  (div6)
    );

    // Reference: one quiet busy cycle, then ceil(n/2) pair cycles or n single cycles.
    function automatic int exp_len(int n, bit s);
        return (n == 0) ? 0 : 1 + (s ? n : (n + 1) / 2);
    endfunction

    function automatic logic [1:0] exp_pulse(int n, bit s, int i);
        if (i == 0) return 2'b00;
        if (s) return ((i - 1) % 2 == 0) ? 2'b10 : 2'b01;
        return (2 * i <= n) ? 2'b11 : 2'b10;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            obs.delete();
            sb.delete();
            rres = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("busy_after_done", int'(busy), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    xfer_t e;
                    int bad;
                    int len;
                    e = sb.pop_front();
                    len = exp_len(e.n, e.s);
                    bad = 0;
                    for (int i = 0; i < obs.size() && i < len; i++)
                        if (obs[i] !== exp_pulse(e.n, e.s, i)) bad++;
                    check($sformatf("seq_len n=%0d s=%0d", e.n, e.s), obs.size(), len);
                    check($sformatf("seq_bits n=%0d s=%0d", e.n, e.s), bad, 0);
                    check($sformatf("div6 n=%0d", e.n), int'(div6), int'(e.n % 6 == 0));
                    check($sformatf("divisable n=%0d", e.n), int'(rres == 0), int'(div6));
                    check("done_lines", int'({X_out, Y_out}), 0);
                end
                obs.delete();
            end else if (busy) begin
                obs.push_back({X_out, Y_out});
            end else if (X_out || Y_out) begin
                check("idle_lines", int'({X_out, Y_out}), 0);
            end
            prev_done = done;
            rres = (start && !busy) ? 0 : (rres + int'(X_out) + int'(Y_out)) % 6;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int n, bit s);
        int t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        if (busy) begin
            check("idle_timeout", 1, 0);
            return;
        end
        start  = 1'b1;
        count  = 8'(n);
        single = s;
        sb.push_back('{n, s});
        tick();
        start  = 1'b0;
        count  = 8'($urandom);
        single = 1'($urandom);
    endtask

    task automatic finish_xfer();
        int t = 0;
        while (busy && t < 5000) begin
            tick();
            t++;
        end
        if (busy) check("done_timeout", 1, 0);
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(X_out), 0);
        check("rst_y", int'(Y_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_div6", int'(div6), 1);
        reset = 1'b0;
        tick();

        send(12, 1'b0);
        send(7, 1'b0);
        send(5, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        send(1, 1'b0);
        send(1, 1'b1);

        send(3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (busy) begin
                start = 1'b1;
                count = 8'd9;
                tick();
            end
        end
        start = 1'b0;
        finish_xfer();

        send(255, 1'b0);
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_x", int'(X_out), 0);
        check("async_rst_y", int'(Y_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_div6", int'(div6), 1);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send(6, 1'b0);

        send(255, 1'b1);
        send(254, 1'b0);
        repeat (25) send(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        finish_xfer();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
